// File: rtl/echo_tof_timer.sv
// Ultrasonic time-of-flight timer: fires a burst, blanks ring-down,
// then times the first synchronized rising echo edge or reports a timeout,
// and finally enforces a hold-off gap before the next shot.
module echo_tof_timer #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned BURST_CYCLES   = 400,
    parameter int unsigned BLANK_CYCLES   = 2000,
    parameter int unsigned TIMEOUT_CYCLES = 60000,
    parameter int unsigned HOLDOFF_CYCLES = 5000
) (
    input  logic             gclk,
    input  logic             rstn,
    input  logic             cfg_done,
    input  logic             start,
    input  logic             echo_in,
    output logic             burst_en,
    output logic             busy,
    output logic [CNT_W-1:0] tof,
    output logic             tof_valid,
    output logic             no_echo
);

    localparam int unsigned HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_LAST_C = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BURST,
        ST_BLANK,
        ST_LISTEN,
        ST_HOLDOFF
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             s1_q, s2_q, s3_q;
    logic             echo_rise;

    logic             burst_en_q, burst_en_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] tof_q, tof_d;
    logic             tof_valid_q, tof_valid_d;
    logic             no_echo_q, no_echo_d;

    assign echo_rise = s2_q & ~s3_q;

    // State, counters and echo synchronizer/edge-detector flops
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            s1_q    <= echo_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
        end
    end

    // Next-state and counter logic; a cfg_done drop while measuring aborts to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                hold_d = '0;
                if (start && cfg_done) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!cfg_done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // BURST may equal BLANK, in which case blanking is skipped entirely
                    if (cnt_d >= BLANK_C) begin
                        state_d = ST_LISTEN;
                    end else if (cnt_d >= BURST_C) begin
                        state_d = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                if (!cfg_done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d >= BLANK_C) begin
                        state_d = ST_LISTEN;
                    end
                end
            end
            ST_LISTEN: begin
                if (!cfg_done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (echo_rise || (cnt_q == LAST_C)) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (hold_q == HOLD_LAST_C) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Output decode: echo capture wins over timeout in the same cycle
    always_comb begin
        burst_en_d  = (state_d == ST_BURST);
        busy_d      = (state_d != ST_IDLE);
        tof_d       = tof_q;
        tof_valid_d = 1'b0;
        no_echo_d   = 1'b0;
        if ((state_q == ST_LISTEN) && cfg_done) begin
            if (echo_rise) begin
                tof_d       = cnt_q;
                tof_valid_d = 1'b1;
            end else if (cnt_q == LAST_C) begin
                tof_d     = '1;
                no_echo_d = 1'b1;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            burst_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            tof_q       <= '0;
            tof_valid_q <= 1'b0;
            no_echo_q   <= 1'b0;
        end else begin
            burst_en_q  <= burst_en_d;
            busy_q      <= busy_d;
            tof_q       <= tof_d;
            tof_valid_q <= tof_valid_d;
            no_echo_q   <= no_echo_d;
        end
    end

    assign burst_en  = burst_en_q;
    assign busy      = busy_q;
    assign tof       = tof_q;
    assign tof_valid = tof_valid_q;
    assign no_echo   = no_echo_q;

endmodule

// File: tb/tb_echo_tof_timer.sv
// Bench for echo_tof_timer: echo waveforms per shot are compared against a
// timing model that finds the first synchronized rising edge in the window.
module tb_echo_tof_timer;

    localparam int unsigned B = 8;
    localparam int unsigned BL = 20;
    localparam int unsigned TO = 100;
    localparam int unsigned H = 10;

    logic        gclk;
    logic        rstn;
    logic        cfg_done;
    logic        start;
    logic        echo_in;
    logic        burst_en;
    logic        busy;
    logic [15:0] tof;
    logic        tof_valid;
    logic        no_echo;

    int          n_checks;
    int          n_err;
    logic        wave [0:127];
    logic [15:0] ref_tof;

    echo_tof_timer #(
        .CNT_W(16),
        .BURST_CYCLES(B),
        .BLANK_CYCLES(BL),
        .TIMEOUT_CYCLES(TO),
        .HOLDOFF_CYCLES(H)
    ) dut (
        .gclk(gclk),
        .rstn(rstn),
        .cfg_done(cfg_done),
        .start(start),
        .echo_in(echo_in),
        .burst_en(burst_en),
        .busy(busy),
        .tof(tof),
        .tof_valid(tof_valid),
        .no_echo(no_echo)
    );

    always #5 gclk = ~gclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    // wave[i] is the echo level during the cycle following edge E0+i
    task automatic set_wave(input int rise, input int pl_start, input int pl_len);
        for (int i = 0; i < 128; i++)
            wave[i] = (i >= rise) || ((i >= pl_start) && (i < pl_start + pl_len));
    endtask

    // Capture at counter k needs echo high in cycle k-2 and low in cycle k-3
    // (two synchronizer stages plus the edge flop); window is [BL, TO-1].
    function automatic void model(output int kk, output bit hit);
        hit = 1'b0;
        kk  = TO - 1;
        for (int k = BL; k <= TO - 1; k++) begin
            if (wave[k-2] && !wave[k-3]) begin
                kk  = k;
                hit = 1'b1;
                break;
            end
        end
    endfunction

    // abort_kind: 0 none, 1 cfg_done drop at counter abort_k, 2 async reset there
    task automatic do_shot(input int pre, input int abort_k, input int abort_kind, input bit start_in_hold);
        int          exp_k;
        bit          hit;
        int          p;
        logic [15:0] exp_tof;
        model(exp_k, hit);
        exp_tof = hit ? 16'(exp_k) : 16'hFFFF;
        p = exp_k + 1;
        echo_in = 1'b0;
        start   = 1'b0;
        repeat (pre) step();
        start = 1'b1;
        step();
        for (int k = 0; k <= p + int'(H) + 3; k++) begin
            echo_in = wave[k];
            start   = start_in_hold && (k == p + 3);
            if (abort_kind == 1 && k == abort_k) begin
                cfg_done = 1'b0;
                step();
                check("abort_burst_en", 32'(burst_en), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_tof_valid", 32'(tof_valid), 0);
                check("abort_no_echo", 32'(no_echo), 0);
                check("abort_tof", 32'(tof), 32'(ref_tof));
                return;
            end
            if (abort_kind == 2 && k == abort_k) begin
                #1 rstn = 1'b0;
                #1;
                check("rst_burst_en", 32'(burst_en), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_tof", 32'(tof), 0);
                check("rst_tof_valid", 32'(tof_valid), 0);
                check("rst_no_echo", 32'(no_echo), 0);
                ref_tof = 16'h0;
                start   = 1'b0;
                echo_in = 1'b0;
                step();
                step();
                rstn = 1'b1;
                step();
                return;
            end
            check("burst_en", 32'(burst_en), 32'(k < int'(B)));
            check("busy", 32'(busy), 32'(k < p + int'(H)));
            check("tof_valid", 32'(tof_valid), 32'(hit && k == p));
            check("no_echo", 32'(no_echo), 32'(!hit && k == p));
            check("tof", 32'(tof), 32'((k >= p) ? exp_tof : ref_tof));
            step();
        end
        start   = 1'b0;
        ref_tof = exp_tof;
    endtask

    initial begin
        gclk     = 1'b0;
        rstn     = 1'b0;
        cfg_done = 1'b0;
        start    = 1'b0;
        echo_in  = 1'b0;
        ref_tof  = 16'h0;
        n_checks = 0;
        n_err    = 0;

        repeat (3) step();
        check("reset_burst_en", 32'(burst_en), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_tof", 32'(tof), 0);
        check("reset_tof_valid", 32'(tof_valid), 0);
        check("reset_no_echo", 32'(no_echo), 0);
        rstn = 1'b1;
        step();

        // start while configuration is incomplete is dropped
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            step();
            check("gate_busy", 32'(busy), 0);
        end
        cfg_done = 1'b1;

        // normal echo at 50 -> tof 52, plus a start dropped during hold-off
        set_wave(50, 200, 0);
        do_shot(4, -1, 0, 1'b1);

        // echo pulse inside blanking only -> timeout
        set_wave(200, 12, 4);
        do_shot(4, -1, 0, 1'b0);

        // echo held high from blanking onward -> no rising edge in window
        set_wave(12, 200, 0);
        do_shot(4, -1, 0, 1'b0);

        // echo edge detected exactly at the last window count
        set_wave(97, 200, 0);
        do_shot(4, -1, 0, 1'b0);

        // abort at counter 5 during burst, then immediate restart
        set_wave(30, 200, 0);
        do_shot(4, 5, 1, 1'b0);
        cfg_done = 1'b1;
        set_wave(30, 200, 0);
        do_shot(0, -1, 0, 1'b0);

        // asynchronous reset mid-listen, then a normal shot
        set_wave(50, 200, 0);
        do_shot(4, 40, 2, 1'b0);
        set_wave(50, 200, 0);
        do_shot(4, -1, 0, 1'b0);

        // randomized echo timing with an optional early glitch pulse
        for (int r = 0; r < 10; r++) begin
            set_wave(int'($urandom_range(0, 110)), int'($urandom_range(0, 60)),
                     int'($urandom_range(0, 4)));
            do_shot(int'($urandom_range(1, 5)), -1, 0, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
